// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart bridge: FSM state encodings and
// the width helper used for the per-bit cycle counters.
package io_uart_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DATA  = 2'd2;
    localparam logic [1:0] STATE_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_START = STATE_START,
        ST_DATA  = STATE_DATA,
        ST_STOP  = STATE_STOP
    } uart_state_t;

    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit queue between the core's write strobe and the TX FSM.
// A push while full is still accepted when a pop frees a slot that cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/io_uart_bridge.sv
// UART peripheral behind the core's ioout/ioin interface: queued 8N1 transmit,
// synchronised 8N1 receive with a single-byte holding register and interrupt.
module io_uart_bridge
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ioout,
    input  logic       io_wr,
    input  logic       io_rd,
    output logic [7:0] ioin,
    output logic       intr,
    output logic       tx_full,
    input  logic       rxd,
    output logic       txd
);

    localparam int          CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic       fifo_pop;
    logic       fifo_empty;
    logic [7:0] fifo_head;

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (io_wr),
        .pop   (fifo_pop),
        .din   (ioout),
        .head  (fifo_head),
        .full  (tx_full),
        .empty (fifo_empty)
    );

    uart_state_t   tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          txd_n;

    // txd is registered from the next-state logic so it never glitches
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd;
        fifo_pop   = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_head;
                    tx_cnt_n   = '0;
                    txd_n      = 1'b0;
                    tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    txd_n      = tx_shift[0];
                    tx_state_n = ST_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        txd_n      = 1'b1;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        txd_n      = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = ST_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    logic rxd_meta, rxd_s, rxd_prev;

    // rxd_prev lets IDLE spot the falling edge of the start bit
    always_ff @(posedge clock) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    uart_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_valid   = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rxd_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_valid   = rxd_s;
                    rx_state_n = ST_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    // A read in the same cycle as a new byte retires the old one, so the new byte lands
    always_ff @(posedge clock) begin
        if (!reset) begin
            ioin <= '0;
            intr <= 1'b0;
        end else if (rx_valid && (!intr || io_rd)) begin
            ioin <= rx_shift;
            intr <= 1'b1;
        end else if (io_rd) begin
            intr <= 1'b0;
        end
    end

endmodule
